// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial subtractor computing (a - b) mod 2^WIDTH, one bit per clock,
//   LSB first, with a single borrow flip-flop. Controlled by a start/done
//   handshake: IDLE -> SHIFT (WIDTH cycles) -> DONE (one cycle) -> IDLE.
//
// Optional feature macro: SERIAL_SUB_OVF_EN
//   When defined, adds the ovf port and the two operand-MSB capture flops.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   request, only honoured in IDLE
//   a, b   in   minuend / subtrahend, captured when start is accepted
//   busy   out  high while bits are being processed
//   done   out  one-cycle pulse when diff/bout/zero(/ovf) are updated
//   diff   out  (a - b) mod 2^WIDTH
//   bout   out  final borrow (a < b unsigned)
//   zero   out  diff == 0
//   ovf    out  signed overflow (only with SERIAL_SUB_OVF_EN)
// ---------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res;
  logic             r_br;
  logic [CNT_W-1:0] r_cnt;

  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_zero;

  logic             w_load;
  logic             w_step;
  logic             w_fin;
  logic             w_busy_nxt;

  logic             w_x;
  logic             w_y;
  logic             w_d;
  logic             w_br_nxt;

  // Single-bit full subtractor on the current LSBs and the stored borrow.
  always_comb begin
    w_x      = r_a_sr[0];
    w_y      = r_b_sr[0];
    w_d      = w_x ^ w_y ^ r_br;
    w_br_nxt = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; start outside IDLE is simply dropped.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_SHIFT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (r_cnt == LAST_BIT) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM output decode: datapath enables and next values of registered flags.
  always_comb begin
    w_load = 1'b0;
    w_step = 1'b0;
    w_fin  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_load = start;
      end
      S_SHIFT: begin
        w_step = 1'b1;
      end
      S_DONE: begin
        w_fin = 1'b1;
      end
      default: begin
        w_load = 1'b0;
      end
    endcase
    // busy is registered, so it follows the state being entered.
    w_busy_nxt = (w_state_nxt == S_SHIFT);
  end

  // Operand shift registers, borrow, bit counter and result accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sr <= {WIDTH{1'b0}};
      r_b_sr <= {WIDTH{1'b0}};
      r_res  <= {WIDTH{1'b0}};
      r_br   <= 1'b0;
      r_cnt  <= {CNT_W{1'b0}};
    end else if (w_load) begin
      r_a_sr <= a;
      r_b_sr <= b;
      r_br   <= 1'b0;
      r_cnt  <= {CNT_W{1'b0}};
    end else if (w_step) begin
      r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
      r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
      // New bit enters at the MSB; after WIDTH steps bit 0 has reached the LSB.
      r_res  <= {w_d, r_res[WIDTH-1:1]};
      r_br   <= w_br_nxt;
      r_cnt  <= r_cnt + CNT_W'(1);
    end else begin
      r_a_sr <= r_a_sr;
      r_b_sr <= r_b_sr;
      r_res  <= r_res;
      r_br   <= r_br;
      r_cnt  <= r_cnt;
    end
  end

  // Registered handshake flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_fin;
    end
  end

  // Result outputs: only updated on the DONE cycle, held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_diff <= {WIDTH{1'b0}};
      r_bout <= 1'b0;
      r_zero <= 1'b1;
    end else if (w_fin) begin
      r_diff <= r_res;
      r_bout <= r_br;
      r_zero <= (r_res == {WIDTH{1'b0}});
    end else begin
      r_diff <= r_diff;
      r_bout <= r_bout;
      r_zero <= r_zero;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  // Operand sign capture and signed-overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_load) begin
      r_a_msb <= a[WIDTH-1];
      r_b_msb <= b[WIDTH-1];
      r_ovf   <= r_ovf;
    end else if (w_fin) begin
      r_a_msb <= r_a_msb;
      r_b_msb <= r_b_msb;
      // Overflow only possible with opposite signs and a result sign flip.
      r_ovf   <= (r_a_msb != r_b_msb) && (r_res[WIDTH-1] != r_a_msb);
    end else begin
      r_a_msb <= r_a_msb;
      r_b_msb <= r_b_msb;
      r_ovf   <= r_ovf;
    end
  end

  assign ovf = r_ovf;
`endif

  assign busy = r_busy;
  assign done = r_done;
  assign diff = r_diff;
  assign bout = r_bout;
  assign zero = r_zero;

endmodule
